// File: rtl/servile_loader_pkg.sv
// Shared definitions for the program-SRAM boot loader: FSM encoding and
// the fixed Wishbone byte-select pattern.
package servile_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_READ    = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam logic [3:0] SEL_ALL = 4'hF;

endpackage

// File: rtl/servile_byte_packer.sv
// Packs four accepted stream bytes little-endian into one 32-bit word.
// word_full flags the cycle in which the fourth byte is being accepted.
module servile_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0]  cnt_q,  cnt_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear) begin
            cnt_d = 2'd0;
        end else if (accept) begin
            case (cnt_q)
                2'd0:    word_d[7:0]   = byte_in;
                2'd1:    word_d[15:8]  = byte_in;
                2'd2:    word_d[23:16] = byte_in;
                default: word_d[31:24] = byte_in;
            endcase
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            word_q <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word      = word_q;
    assign word_full = accept & ~clear & (cnt_q == 2'd3);

endmodule

// File: rtl/servile_wb_loader.sv
// Wishbone initiator that fills the program half of the shared SRAM from a
// byte stream, optionally reading each word back and flagging the first mismatch.
module servile_wb_loader
    import servile_loader_pkg::*;
#(
    parameter int unsigned depth   = 256,
    parameter int unsigned aw      = $clog2(depth),
    parameter int unsigned n_words = depth / 8,
    parameter bit          verify  = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_byte_valid,
    input  logic [7:0]    i_byte,
    output logic          o_byte_ready,
    output logic [aw-3:0] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_stb,
    input  logic [31:0]   i_wb_rdt,
    input  logic          i_wb_ack,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [aw-3:0] o_err_adr
);

    localparam int unsigned ADR_W = aw - 2;
    localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(n_words - 1);

    state_e           state_q, state_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [ADR_W-1:0] err_adr_q, err_adr_d;
    logic             stb_q, stb_d;
    logic             we_q, we_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             advance;

    logic             pk_clear;
    logic             pk_accept;
    logic [31:0]      pk_word;
    logic             pk_full;

    // ready_q is only ever high in COLLECT, so it alone qualifies a byte.
    assign pk_accept = i_byte_valid & ready_q;

    servile_byte_packer u_packer (
        .clk       (i_clk),
        .rst       (i_rst),
        .clear     (pk_clear),
        .accept    (pk_accept),
        .byte_in   (i_byte),
        .word      (pk_word),
        .word_full (pk_full)
    );

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        err_adr_d = err_adr_q;
        stb_d     = stb_q;
        we_d      = we_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        pk_clear  = 1'b0;
        advance   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    adr_d     = '0;
                    err_d     = 1'b0;
                    err_adr_d = '0;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                    ready_d   = 1'b1;
                    pk_clear  = 1'b1;
                    state_d   = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (pk_full) begin
                    ready_d = 1'b0;
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (stb_q && i_wb_ack) begin
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    if (verify) begin
                        state_d = ST_READ;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_READ: begin
                // The first READ cycle is the mandatory strobe gap after the write ack.
                if (!stb_q) begin
                    stb_d = 1'b1;
                end else if (i_wb_ack) begin
                    stb_d = 1'b0;
                    if ((i_wb_rdt != pk_word) && !err_q) begin
                        err_d     = 1'b1;
                        err_adr_d = adr_q;
                    end
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (advance) begin
            if (adr_q == LAST_ADR) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_DONE;
            end else begin
                adr_d    = adr_q + 1'b1;
                pk_clear = 1'b1;
                ready_d  = 1'b1;
                state_d  = ST_COLLECT;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            adr_q     <= '0;
            err_adr_q <= '0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            err_adr_q <= err_adr_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign o_byte_ready = ready_q;
    assign o_wb_adr     = adr_q;
    assign o_wb_dat     = pk_word;
    assign o_wb_sel     = SEL_ALL;
    assign o_wb_we      = we_q;
    assign o_wb_stb     = stb_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_err_adr    = err_adr_q;

endmodule

// File: tb/tb_servile_wb_loader.sv
// Directed bench for servile_wb_loader: instance 0 verifies readback, instance 1
// is write-only; a single responder process models both SRAM ports.
module tb_servile_wb_loader;

    logic        clk;
    logic        rst;
    logic        start_s [2];
    logic        bvalid  [2];
    logic [7:0]  bdata   [2];
    logic        ready   [2];
    logic [5:0]  wb_adr  [2];
    logic [31:0] wb_dat  [2];
    logic [3:0]  wb_sel  [2];
    logic        wb_we   [2];
    logic        wb_stb  [2];
    logic [31:0] rdt     [2];
    logic        ack     [2];
    logic        busy    [2];
    logic        done    [2];
    logic        err     [2];
    logic [5:0]  err_adr [2];

    int          wcnt [2];
    int          cur_wait [2];
    int          max_wait [2];
    int          wr_cnt [2];
    int          rd_cnt [2];
    int          viol [2];
    bit          active [2];
    bit          flip_en [2];
    logic [5:0]  cap_adr [2];
    logic [31:0] cap_dat [2];
    logic        cap_we [2];
    logic [31:0] mem [2][64];

    int errors = 0;
    int checks = 0;

    servile_wb_loader #(.depth(256), .verify(1'b1)) u_dut_v (
        .i_clk(clk), .i_rst(rst), .i_start(start_s[0]),
        .i_byte_valid(bvalid[0]), .i_byte(bdata[0]), .o_byte_ready(ready[0]),
        .o_wb_adr(wb_adr[0]), .o_wb_dat(wb_dat[0]), .o_wb_sel(wb_sel[0]),
        .o_wb_we(wb_we[0]), .o_wb_stb(wb_stb[0]), .i_wb_rdt(rdt[0]), .i_wb_ack(ack[0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_err(err[0]), .o_err_adr(err_adr[0])
    );

    servile_wb_loader #(.depth(256), .verify(1'b0)) u_dut_w (
        .i_clk(clk), .i_rst(rst), .i_start(start_s[1]),
        .i_byte_valid(bvalid[1]), .i_byte(bdata[1]), .o_byte_ready(ready[1]),
        .o_wb_adr(wb_adr[1]), .o_wb_dat(wb_dat[1]), .o_wb_sel(wb_sel[1]),
        .o_wb_we(wb_we[1]), .o_wb_stb(wb_stb[1]), .i_wb_rdt(rdt[1]), .i_wb_ack(ack[1]),
        .o_busy(busy[1]), .o_done(done[1]), .o_err(err[1]), .o_err_adr(err_adr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM responder: acks after cur_wait cycles and tallies protocol violations
    // (strobe right after an ack, strobe dropped early, request changing mid-cycle).
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                ack[g] = 1'b0; rdt[g] = 32'd0; wcnt[g] = 0; cur_wait[g] = 0;
                active[g] = 1'b0; wr_cnt[g] = 0; rd_cnt[g] = 0; viol[g] = 0;
                for (int i = 0; i < 64; i++) mem[g][i] = 32'hA5A5_0000 | i;
            end else if (ack[g]) begin
                if (wb_stb[g]) viol[g]++;
                ack[g] = 1'b0; wcnt[g] = 0; active[g] = 1'b0;
                cur_wait[g] = $urandom_range(0, max_wait[g]);
            end else if (wb_stb[g]) begin
                if (active[g] && (wb_adr[g] !== cap_adr[g] || wb_we[g] !== cap_we[g] ||
                                  wb_dat[g] !== cap_dat[g])) viol[g]++;
                if (wb_sel[g] !== 4'hF) viol[g]++;
                active[g] = 1'b1; cap_adr[g] = wb_adr[g]; cap_we[g] = wb_we[g]; cap_dat[g] = wb_dat[g];
                if (wcnt[g] >= cur_wait[g]) begin
                    ack[g] = 1'b1;
                    if (wb_we[g]) begin
                        mem[g][wb_adr[g]] = wb_dat[g];
                        wr_cnt[g]++;
                    end else begin
                        rd_cnt[g]++;
                        rdt[g] = mem[g][wb_adr[g]] ^
                                 ((flip_en[g] && (wb_adr[g] == 6'd5 || wb_adr[g] == 6'd9)) ? 32'd1 : 32'd0);
                    end
                end else begin
                    wcnt[g]++;
                end
            end else begin
                if (active[g]) viol[g]++;
                active[g] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] stream_byte(input logic [7:0] base, input int step, input int i);
        return base + 8'(i * step);
    endfunction

    function automatic logic [31:0] exp_word(input logic [7:0] base, input int step, input int w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = stream_byte(base, step, 4 * w + k);
        return r;
    endfunction

    task automatic chk_reset(input int d, input string pfx);
        chk({pfx, "_ready"},   ready[d],   0);
        chk({pfx, "_stb"},     wb_stb[d],  0);
        chk({pfx, "_we"},      wb_we[d],   0);
        chk({pfx, "_adr"},     wb_adr[d],  0);
        chk({pfx, "_dat"},     wb_dat[d],  0);
        chk({pfx, "_sel"},     wb_sel[d],  32'hF);
        chk({pfx, "_busy"},    busy[d],    0);
        chk({pfx, "_done"},    done[d],    0);
        chk({pfx, "_err"},     err[d],     0);
        chk({pfx, "_err_adr"}, err_adr[d], 0);
    endtask

    task automatic pulse_start(input int d);
        start_s[d] = 1'b1;
        @(negedge clk);
        start_s[d] = 1'b0;
    endtask

    task automatic send_byte(input int d, input logic [7:0] val, output bit ok);
        int t = 0;
        bvalid[d] = 1'b1;
        bdata[d]  = val;
        while (!ready[d] && t < 400) begin
            @(negedge clk);
            t++;
        end
        ok = ready[d];
        if (!ok) chk("byte_ready_timeout", ready[d], 1);
        @(negedge clk);
        bvalid[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int t = 0;
        while (!done[d] && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("done_wait", done[d], 1);
    endtask

    task automatic start_and_check(input int d);
        pulse_start(d);
        chk("start_busy",  busy[d],   1);
        chk("start_done",  done[d],   0);
        chk("start_err",   err[d],    0);
        chk("start_adr",   wb_adr[d], 0);
        chk("start_ready", ready[d],  1);
    endtask

    task automatic stream(input int d, input logic [7:0] base, input int step, input int n,
                          input int max_gap, input bit dbl_start, input bit chk_first);
        bit ok;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send_byte(d, stream_byte(base, step, i), ok);
            if (!ok) break;
            if (chk_first && i == 3) begin
                chk("first_stb", wb_stb[d], 1);
                chk("first_we",  wb_we[d],  1);
                chk("first_adr", wb_adr[d], 0);
                chk("first_dat", wb_dat[d], exp_word(base, step, 0));
            end
            if (dbl_start && i == 10) pulse_start(d);
        end
    endtask

    task automatic chk_words(input int d, input logic [7:0] base, input int step, input string pfx);
        for (int w = 0; w < 32; w++)
            chk($sformatf("%s_word%0d", pfx, w), mem[d][w], exp_word(base, step, w));
    endtask

    initial begin
        int wr0, rd0;
        rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            start_s[g] = 1'b0; bvalid[g] = 1'b0; bdata[g] = 8'd0;
            max_wait[g] = 0; flip_en[g] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset(0, "rst0");
        chk_reset(1, "rst1");

        // Full load with readback, no gaps; a second start mid-load must be ignored.
        wr0 = wr_cnt[0]; rd0 = rd_cnt[0];
        start_and_check(0);
        stream(0, 8'h00, 1, 128, 0, 1'b1, 1'b1);
        wait_done(0);
        chk_words(0, 8'h00, 1, "full");
        chk("full_word0",  mem[0][0],  32'h0302_0100);
        chk("full_word31", mem[0][31], 32'h7F7E_7D7C);
        for (int i = 32; i < 64; i++)
            chk($sformatf("rf_untouched%0d", i), mem[0][i], 32'hA5A5_0000 | i);
        chk("full_err",    err[0],            0);
        chk("full_busy",   busy[0],           0);
        chk("full_writes", wr_cnt[0] - wr0,   32);
        chk("full_reads",  rd_cnt[0] - rd0,   32);
        chk("full_proto",  viol[0],           0);
        repeat (5) @(negedge clk);
        chk("done_held",   done[0],           1);

        // Gaps, wait states and readback corruption at words 5 and 9.
        max_wait[0] = 3; flip_en[0] = 1'b1;
        wr0 = wr_cnt[0]; rd0 = rd_cnt[0];
        start_and_check(0);
        stream(0, 8'h5A, 37, 128, 3, 1'b0, 1'b0);
        wait_done(0);
        chk_words(0, 8'h5A, 37, "gap");
        chk("gap_err",     err[0],          1);
        chk("gap_err_adr", err_adr[0],      5);
        chk("gap_writes",  wr_cnt[0] - wr0, 32);
        chk("gap_reads",   rd_cnt[0] - rd0, 32);
        chk("gap_proto",   viol[0],         0);

        // Reset while word 3 is being written, then reload from word 0.
        flip_en[0] = 1'b0;
        start_and_check(0);
        stream(0, 8'h11, 3, 16, 0, 1'b0, 1'b0);
        #2;
        chk("midrst_stb", wb_stb[0], 1);
        chk("midrst_adr", wb_adr[0], 3);
        rst = 1'b1;
        #1;
        chk_reset(0, "midrst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        max_wait[0] = 2;
        start_and_check(0);
        stream(0, 8'h11, 3, 128, 1, 1'b0, 1'b0);
        wait_done(0);
        chk_words(0, 8'h11, 3, "reload");
        chk("reload_err",    err[0],    0);
        chk("reload_writes", wr_cnt[0], 32);
        chk("reload_reads",  rd_cnt[0], 32);
        chk("reload_proto",  viol[0],   0);

        // Write-only instance: same stream, no read cycles at all.
        max_wait[1] = 2;
        start_and_check(1);
        stream(1, 8'h00, 1, 128, 2, 1'b0, 1'b1);
        wait_done(1);
        chk_words(1, 8'h00, 1, "wo");
        chk("wo_err",    err[1],    0);
        chk("wo_busy",   busy[1],   0);
        chk("wo_writes", wr_cnt[1], 32);
        chk("wo_reads",  rd_cnt[1], 0);
        chk("wo_proto",  viol[1],   0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
